// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: NUM_CH independent counters, each with its own
// loadable terminal count, run control and periodic/one-shot mode.

module tick_gen_ch #(
    parameter int CNT_W      = 17,
    parameter int DEFAULT_TC = 104686
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             oneshot_i,
    input  logic             sync_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_val_i,
    output logic             tick_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tc_q, tc_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic               mode_q, mode_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= CNT_W'(DEFAULT_TC);
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        mode_d  = mode_q;
        // Compare below still sees tc_q, so a load takes effect on the next edge.
        tc_d    = ld_i ? ld_val_i : tc_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run_i) begin
                    state_d = RUN;
                    mode_d  = oneshot_i;
                end
            end
            RUN: begin
                if (!run_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sync_i) begin
                    cnt_d = '0;
                end else if (cnt_q >= tc_q) begin
                    // ">=" rather than "==" so a shrunk tc can't wrap the counter.
                    tick_d = 1'b1;
                    cnt_d  = '0;
                    if (mode_q) state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d = '0;
                if (!run_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    assign tick_o = tick_q;
    assign busy_o = busy_q;
endmodule

module tick_gen_multi #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 17,
    parameter int DEFAULT_TC = 104686,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] run,
    input  logic [NUM_CH-1:0] oneshot,
    input  logic              sync,
    input  logic              load,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [CNT_W-1:0]  load_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);
    logic [NUM_CH-1:0] ld_sel;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Out-of-range indices match no channel, so they are dropped here.
        assign ld_sel[gi] = load && (load_ch == CH_W'(gi));

        tick_gen_ch #(
            .CNT_W      (CNT_W),
            .DEFAULT_TC (DEFAULT_TC)
        ) u_ch (
            .clk_i     (clk_in),
            .rst_i     (rst),
            .run_i     (run[gi]),
            .oneshot_i (oneshot[gi]),
            .sync_i    (sync),
            .ld_i      (ld_sel[gi]),
            .ld_val_i  (load_val),
            .tick_o    (tick[gi]),
            .busy_o    (busy[gi])
        );
    end
endmodule
